// File: rtl/cy_status_event_ctrl_if.sv
// Read handshake between the firmware-side strobe logic (master) and the
// status event controller (slave).
interface cy_status_event_ctrl_if;
  logic       rd_req;
  logic       rd_ack;
  logic [7:0] snapshot;

  modport master (output rd_req, input rd_ack, input snapshot);
  modport slave  (input rd_req, output rd_ack, output snapshot);
endinterface

// File: rtl/cy_status_event_ctrl.sv
// Event capture and read-clear controller feeding the UDB status register:
// sticky/level status bits, overflow tracking, level interrupt, 4-phase read.
module cy_status_event_ctrl #(
  parameter int unsigned NumInputs  = 7,
  parameter logic [6:0]  EdgeMask   = 7'h7F,
  parameter logic [6:0]  IntMask    = 7'h7F,
  parameter bit          OverflowEn = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [6:0]                   event_in,
  cy_status_event_ctrl_if.slave        rd,
  output logic [7:0]                   status_out,
  output logic                         intr
);

  localparam logic [6:0] ActMask = 7'((8'd1 << NumInputs) - 8'd1);

  typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR, ACK} state_e;

  state_e     state_q, state_d;
  logic [6:0] event_q, event_d;
  logic [6:0] sticky_q, sticky_d;
  logic       ovf_q, ovf_d;
  logic [7:0] snapshot_q, snapshot_d;
  logic       rd_ack_q, rd_ack_d;
  logic       intr_q, intr_d;
  logic [6:0] rise;
  logic [7:0] clr;
  logic [7:0] status;

  always_comb begin
    rise    = event_in & ~event_q & ActMask;
    event_d = event_in & ActMask;
    // Only bits that were in the snapshot may be cleared; a new rise wins.
    clr      = (state_q == CLEAR) ? snapshot_q : 8'h00;
    sticky_d = ((sticky_q & ~clr[6:0]) | rise) & EdgeMask;
    ovf_d    = OverflowEn & ((ovf_q & ~clr[7]) | (|(rise & sticky_q & ~clr[6:0])));

    status = {ovf_q, sticky_q | (event_q & ~EdgeMask)};
    intr_d = (|(status[6:0] & IntMask)) | status[7];

    state_d    = state_q;
    snapshot_d = snapshot_q;
    case (state_q)
      IDLE:    if (rd.rd_req) state_d = CAPTURE;
      CAPTURE: begin
        snapshot_d = status;
        state_d    = CLEAR;
      end
      CLEAR:   state_d = ACK;
      ACK:     if (!rd.rd_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_ack_d = (state_d == ACK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      event_q    <= '0;
      sticky_q   <= '0;
      ovf_q      <= 1'b0;
      snapshot_q <= '0;
      rd_ack_q   <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      event_q    <= event_d;
      sticky_q   <= sticky_d;
      ovf_q      <= ovf_d;
      snapshot_q <= snapshot_d;
      rd_ack_q   <= rd_ack_d;
      intr_q     <= intr_d;
    end
  end

  assign status_out  = status;
  assign intr        = intr_q;
  assign rd.rd_ack   = rd_ack_q;
  assign rd.snapshot = snapshot_q;

endmodule

// File: tb/tb_cy_status_event_ctrl.sv
// Directed bench for cy_status_event_ctrl: three parameterisations driven
// with hand-computed step-by-step expectations.
module tb_cy_status_event_ctrl;

  logic       clock;
  logic       reset_n;
  logic [6:0] ev0, ev1, ev2;
  logic [7:0] st0, st1, st2;
  logic       in0, in1, in2;
  int         checks;
  int         errors;

  cy_status_event_ctrl_if if0();
  cy_status_event_ctrl_if if1();
  cy_status_event_ctrl_if if2();

  cy_status_event_ctrl u0 (
    .clock(clock), .reset_n(reset_n), .event_in(ev0), .rd(if0),
    .status_out(st0), .intr(in0));

  cy_status_event_ctrl #(.EdgeMask(7'h7E), .IntMask(7'h01), .OverflowEn(1'b0)) u1 (
    .clock(clock), .reset_n(reset_n), .event_in(ev1), .rd(if1),
    .status_out(st1), .intr(in1));

  cy_status_event_ctrl #(.NumInputs(4), .IntMask(7'h00)) u2 (
    .clock(clock), .reset_n(reset_n), .event_in(ev2), .rd(if2),
    .status_out(st2), .intr(in2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    ev0 = 7'h7F; ev1 = 7'h00; ev2 = 7'h00;
    if0.rd_req = 1'b0; if1.rd_req = 1'b0; if2.rd_req = 1'b0;

    // Reset with all events high
    step(); step();
    chk("rst_status", st0, 8'h00);
    chk("rst_intr", in0, 0);
    chk("rst_ack", if0.rd_ack, 0);
    chk("rst_snap", if0.snapshot, 8'h00);
    reset_n = 1'b1;
    step();
    chk("rel_status", st0, 8'h7F);
    chk("rel_intr0", in0, 0);
    step();
    chk("rel_intr1", in0, 1);

    // Read to clear everything
    if0.rd_req = 1'b1;
    step();
    chk("r0_ack_k", if0.rd_ack, 0);
    step();
    chk("r0_snap", if0.snapshot, 8'h7F);
    chk("r0_ack_k1", if0.rd_ack, 0);
    step();
    chk("r0_ack_k2", if0.rd_ack, 1);
    chk("r0_status", st0, 8'h00);
    step();
    chk("r0_intr", in0, 0);
    chk("r0_ack_hold", if0.rd_ack, 1);
    if0.rd_req = 1'b0; ev0 = 7'h00;
    step();
    chk("r0_ack_fall", if0.rd_ack, 0);

    // Single sticky read on bit 2
    ev0 = 7'h04;
    step();
    chk("s_status", st0, 8'h04);
    ev0 = 7'h00;
    step();
    chk("s_status_hold", st0, 8'h04);
    chk("s_intr", in0, 1);
    if0.rd_req = 1'b1;
    step();
    chk("s_ack_k", if0.rd_ack, 0);
    step();
    chk("s_snap", if0.snapshot, 8'h04);
    step();
    chk("s_ack", if0.rd_ack, 1);
    chk("s_status_clr", st0, 8'h00);
    step();
    chk("s_intr_clr", in0, 0);
    if0.rd_req = 1'b0;
    step();
    chk("s_ack_fall", if0.rd_ack, 0);

    // Overflow: two rises on bit 0 without a read
    ev0 = 7'h01; step();
    ev0 = 7'h00; step();
    chk("o_status1", st0, 8'h01);
    ev0 = 7'h01; step();
    chk("o_status2", st0, 8'h81);
    ev0 = 7'h00;
    if0.rd_req = 1'b1;
    step(); step();
    chk("o_snap", if0.snapshot, 8'h81);
    step();
    chk("o_status_clr", st0, 8'h00);
    chk("o_ack", if0.rd_ack, 1);
    if0.rd_req = 1'b0;
    step();

    // Collision: rise on bit 1 during CLEAR
    ev0 = 7'h02; step();
    chk("c_status", st0, 8'h02);
    ev0 = 7'h00; step();
    if0.rd_req = 1'b1;
    step();
    step();
    chk("c_snap", if0.snapshot, 8'h02);
    ev0 = 7'h02;
    step();
    chk("c_ack", if0.rd_ack, 1);
    chk("c_status_keep", st0, 8'h02);
    ev0 = 7'h00;
    step();
    chk("c_no_ovf", st0, 8'h02);
    if0.rd_req = 1'b0;
    step();
    chk("c_ack_fall", if0.rd_ack, 0);

    // rd_req dropped after one cycle
    if0.rd_req = 1'b1;
    step();
    if0.rd_req = 1'b0;
    step();
    chk("p_ack_clear", if0.rd_ack, 0);
    chk("p_snap", if0.snapshot, 8'h02);
    step();
    chk("p_ack", if0.rd_ack, 1);
    chk("p_status", st0, 8'h00);
    step();
    chk("p_ack_one", if0.rd_ack, 0);
    step();
    chk("p_ack_stay", if0.rd_ack, 0);

    // Reset in the CLEAR state
    ev0 = 7'h08; step();
    chk("x_status", st0, 8'h08);
    ev0 = 7'h00;
    if0.rd_req = 1'b1;
    step(); step();
    chk("x_snap", if0.snapshot, 8'h08);
    reset_n = 1'b0;
    #1;
    chk("x_ack_rst", if0.rd_ack, 0);
    chk("x_status_rst", st0, 8'h00);
    chk("x_snap_rst", if0.snapshot, 8'h00);
    step();
    chk("x_ack_rst2", if0.rd_ack, 0);
    reset_n = 1'b1;
    step();
    chk("x_ack_k", if0.rd_ack, 0);
    step(); step();
    chk("x_ack_fresh", if0.rd_ack, 1);
    chk("x_snap_fresh", if0.snapshot, 8'h00);
    if0.rd_req = 1'b0;
    step();
    chk("x_ack_fall", if0.rd_ack, 0);

    // u1: level bit 0, IntMask 01, overflow disabled
    ev1 = 7'h04; step();
    ev1 = 7'h00; step();
    ev1 = 7'h04; step();
    ev1 = 7'h00; step();
    chk("l_no_ovf", st1, 8'h04);
    chk("l_intr_masked", in1, 0);
    ev1 = 7'h01; step();
    chk("l_status", st1, 8'h05);
    step();
    chk("l_intr", in1, 1);
    if1.rd_req = 1'b1;
    step(); step();
    chk("l_snap", if1.snapshot, 8'h05);
    step();
    chk("l_ack", if1.rd_ack, 1);
    chk("l_level_keep", st1, 8'h01);
    if1.rd_req = 1'b0;
    step();
    chk("l_intr_keep", in1, 1);
    ev1 = 7'h00; step();
    chk("l_level_fall", st1, 8'h00);
    step();
    chk("l_intr_fall", in1, 0);

    // u2: IntMask 00, NumInputs 4
    ev2 = 7'h08; step();
    chk("m_status", st2, 8'h08);
    step();
    chk("m_intr", in2, 0);
    ev2 = 7'h7F; step();
    chk("m_width", st2, 8'h0F);
    ev2 = 7'h77; step();
    ev2 = 7'h7F; step();
    chk("m_ovf", st2, 8'h8F);
    step();
    chk("m_intr_ovf", in2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
